memory_stage: RTL and testbench

//  Memory pipeline stage plus its E->M pipeline register. Captures execute results, drives a
//  req/ready data-memory port (byte enables, store lane placement), aligns and extends loads,
//  and produces forward_data_m_o for the execute forwarding muxes. Raises mem_busy_o for the

---
 rtl/memory_stage_pkg.sv | 55 +++++
 rtl/memory_stage_load_align.sv | 39 +++
 rtl/memory_stage.sv | 184 ++++++++++++++++++
 tb/tb_memory_stage.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_stage_pkg.sv
// Shared definitions for the memory stage: access width codes, result
// select codes, the memory-access FSM state type, the E->M pipeline
// register payload, and a helper that flags misaligned accesses.
package memory_stage_pkg;

    // Access width / sign codes. Bit 2 set means zero-extend,
    // bits [1:0] give the size: 01 byte, 10 half, anything else word.
    localparam logic [2:0] WIDTH_W  = 3'b000;
    localparam logic [2:0] WIDTH_B  = 3'b001;
    localparam logic [2:0] WIDTH_H  = 3'b010;
    localparam logic [2:0] WIDTH_BU = 3'b101;
    localparam logic [2:0] WIDTH_HU = 3'b110;

    // Result select codes.
    localparam logic [2:0] RESULT_ALU      = 3'b000;
    localparam logic [2:0] RESULT_MEM      = 3'b001;
    localparam logic [2:0] RESULT_PCPLUS4  = 3'b010;
    localparam logic [2:0] RESULT_UPIMM    = 3'b011;
    localparam logic [2:0] RESULT_PCTARGET = 3'b100;

    // Memory-access FSM states.
    typedef enum logic [1:0] {
        M_IDLE   = 2'd0,
        M_ACCESS = 2'd1,
        M_DONE   = 2'd2
    } m_state_e;

    // Payload carried by the E->M pipeline register.
    typedef struct packed {
        logic [31:0] alu_result;
        logic [31:0] write_data;
        logic [31:0] pc_target;
        logic [31:0] pc_plus4;
        logic [31:0] imm_ext;
        logic [4:0]  rd;
        logic        valid;
        logic [2:0]  width_src;
        logic [2:0]  result_src;
        logic        mem_write;
        logic        reg_write;
    } m_signals_t;

    // Size bits of the width code plus the low address bits -> misaligned.
    function automatic logic is_misaligned(input logic [1:0] size_i,
                                           input logic [1:0] off_i);
        logic mis;
        unique case (size_i)
            2'b01:   mis = 1'b0;
            2'b10:   mis = off_i[0];
            default: mis = (off_i != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/memory_stage_load_align.sv
// Load alignment: picks the addressed byte/half out of a 32-bit memory
// word and sign- or zero-extends it according to the width code.
// Ports:
//   word_i    32  raw word read from memory
//   offset_i  2   byte offset within the word (address bits [1:0])
//   width_i   3   WIDTH_* code
//   data_o    32  aligned, extended result
module memory_stage_load_align
    import memory_stage_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  offset_i,
    input  logic [2:0]  width_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        sign_en;

    always_comb begin
        unique case (offset_i)
            2'd0:    byte_sel = word_i[7:0];
            2'd1:    byte_sel = word_i[15:8];
            2'd2:    byte_sel = word_i[23:16];
            default: byte_sel = word_i[31:24];
        endcase
        half_sel = offset_i[1] ? word_i[31:16] : word_i[15:0];
        // Unsigned variants carry bit 2 of the width code.
        sign_en  = ~width_i[2];

        unique case (width_i[1:0])
            2'b01:   data_o = {{24{sign_en & byte_sel[7]}}, byte_sel};
            2'b10:   data_o = {{16{sign_en & half_sel[15]}}, half_sel};
            default: data_o = word_i;
        endcase
    end

endmodule

// File: rtl/memory_stage.sv
// Memory pipeline stage with its E->M pipeline register.
// Captures execute results, runs a req/ready data-memory access with
// byte-lane placement for stores, aligns/extends loads, produces the
// non-memory forwarding value and raises mem_busy_o while an access is
// outstanding.
// Ports:
//   clk_i, reset_i           clock, synchronous active-high reset
//   *_e_i                    execute-stage results and control
//   stall_m_i, flush_m_i     hold / clear the M register (flush wins)
//   dmem_*                   data-memory port (req held until ready)
//   *_m_o                    registered copies and M-stage results
//   mem_busy_o               access outstanding, memory not yet ready
//   misaligned_o             current M instruction is a misaligned mem op
//   m_state_o                current FSM state (observation only)
// Handshake: dmem_req_o stays high with stable addr/we/wdata/be until the
// cycle in which dmem_ready_i is seen high; that cycle completes the access.
module memory_stage
    import memory_stage_pkg::*;
(
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [31:0] alu_result_e_i,
    input  logic [31:0] write_data_e_i,
    input  logic [31:0] pc_target_e_i,
    input  logic [31:0] pc_plus4_e_i,
    input  logic [31:0] imm_ext_e_i,
    input  logic [4:0]  rd_e_i,
    input  logic        valid_e_i,
    input  logic [2:0]  width_src_e_i,
    input  logic [2:0]  result_src_e_i,
    input  logic        mem_write_e_i,
    input  logic        reg_write_e_i,
    input  logic        stall_m_i,
    input  logic        flush_m_i,
    input  logic        dmem_ready_i,
    input  logic [31:0] dmem_rdata_i,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [31:0] dmem_wdata_o,
    output logic [3:0]  dmem_be_o,
    output logic [31:0] alu_result_m_o,
    output logic [31:0] pc_plus4_m_o,
    output logic [31:0] imm_ext_m_o,
    output logic [31:0] pc_target_m_o,
    output logic [31:0] load_data_m_o,
    output logic [31:0] forward_data_m_o,
    output logic [4:0]  rd_m_o,
    output logic        reg_write_m_o,
    output logic        valid_m_o,
    output logic [2:0]  result_src_m_o,
    output logic [2:0]  width_src_m_o,
    output logic        mem_busy_o,
    output logic        misaligned_o,
    output logic [1:0]  m_state_o
);

    m_signals_t  m_q, m_d;
    m_state_e    state_q, state_d;
    logic [31:0] load_buf_q, load_buf_d;

    logic        new_mem_op, new_aligned;
    logic        mem_op, misaligned, is_load;
    logic [3:0]  store_be;
    logic [31:0] store_wdata;
    logic [31:0] align_word, aligned_data;
    logic [1:0]  offset;

    always_comb begin
        m_d.alu_result = alu_result_e_i;
        m_d.write_data = write_data_e_i;
        m_d.pc_target  = pc_target_e_i;
        m_d.pc_plus4   = pc_plus4_e_i;
        m_d.imm_ext    = imm_ext_e_i;
        m_d.rd         = rd_e_i;
        m_d.valid      = valid_e_i;
        m_d.width_src  = width_src_e_i;
        m_d.result_src = result_src_e_i;
        m_d.mem_write  = mem_write_e_i;
        m_d.reg_write  = reg_write_e_i;
    end

    // Classification of the incoming instruction decides the FSM state it
    // enters with, so the request goes out in its first M cycle.
    assign new_mem_op  = valid_e_i & (mem_write_e_i | (result_src_e_i == RESULT_MEM));
    assign new_aligned = ~is_misaligned(width_src_e_i[1:0], alu_result_e_i[1:0]);

    assign offset     = m_q.alu_result[1:0];
    assign mem_op     = m_q.valid & (m_q.mem_write | (m_q.result_src == RESULT_MEM));
    assign misaligned = mem_op & is_misaligned(m_q.width_src[1:0], offset);
    assign is_load    = mem_op & ~m_q.mem_write;

    always_comb begin
        state_d    = state_q;
        load_buf_d = load_buf_q;
        if (!stall_m_i) begin
            state_d = (new_mem_op & new_aligned) ? M_ACCESS : M_IDLE;
        end else if ((state_q == M_ACCESS) && dmem_ready_i) begin
            state_d    = M_DONE;
            load_buf_d = dmem_rdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i || flush_m_i) begin
            m_q        <= '0;
            state_q    <= M_IDLE;
            load_buf_q <= '0;
        end else begin
            if (!stall_m_i) begin
                m_q <= m_d;
            end
            state_q    <= state_d;
            load_buf_q <= load_buf_d;
        end
    end

    // Store lane placement; halves are only ever at offset 0 or 2 here.
    always_comb begin
        unique case (m_q.width_src[1:0])
            2'b01: begin
                store_wdata = {4{m_q.write_data[7:0]}};
                store_be    = 4'b0001 << offset;
            end
            2'b10: begin
                store_wdata = {2{m_q.write_data[15:0]}};
                store_be    = 4'b0011 << offset;
            end
            default: begin
                store_wdata = m_q.write_data;
                store_be    = 4'b1111;
            end
        endcase
    end

    // The FSM only enters M_ACCESS for aligned mem ops, so req implies one.
    assign dmem_req_o   = (state_q == M_ACCESS);
    assign dmem_we_o    = dmem_req_o & m_q.mem_write;
    assign dmem_addr_o  = {m_q.alu_result[31:2], 2'b00};
    assign dmem_be_o    = dmem_req_o ? (m_q.mem_write ? store_be : 4'b1111) : 4'b0000;
    assign dmem_wdata_o = dmem_we_o ? store_wdata : 32'h0;
    assign mem_busy_o   = (state_q == M_ACCESS) & ~dmem_ready_i;

    // In the ready cycle the raw read data is used directly, afterwards the
    // buffered copy keeps the result stable while the stage is held.
    assign align_word = (state_q == M_DONE) ? load_buf_q : dmem_rdata_i;

    memory_stage_load_align u_load_align (
        .word_i   (align_word),
        .offset_i (offset),
        .width_i  (m_q.width_src),
        .data_o   (aligned_data)
    );

    always_comb begin
        load_data_m_o = 32'h0;
        if (is_load && !misaligned &&
            (((state_q == M_ACCESS) && dmem_ready_i) || (state_q == M_DONE))) begin
            load_data_m_o = aligned_data;
        end
    end

    always_comb begin
        unique case (m_q.result_src)
            RESULT_PCPLUS4:  forward_data_m_o = m_q.pc_plus4;
            RESULT_UPIMM:    forward_data_m_o = m_q.imm_ext;
            RESULT_PCTARGET: forward_data_m_o = m_q.pc_target;
            default:         forward_data_m_o = m_q.alu_result;
        endcase
    end

    assign alu_result_m_o = m_q.alu_result;
    assign pc_plus4_m_o   = m_q.pc_plus4;
    assign imm_ext_m_o    = m_q.imm_ext;
    assign pc_target_m_o  = m_q.pc_target;
    assign rd_m_o         = m_q.rd;
    assign reg_write_m_o  = m_q.reg_write;
    assign valid_m_o      = m_q.valid;
    assign result_src_m_o = m_q.result_src;
    assign width_src_m_o  = m_q.width_src;
    assign misaligned_o   = misaligned;
    assign m_state_o      = state_q;

endmodule

// File: tb/tb_memory_stage.sv
module tb_memory_stage;

    typedef struct {
        logic [31:0] alu, wd, pcp4, pct, imm;
        logic [4:0]  rd;
        logic        valid;
        logic [2:0]  width, rsrc;
        logic        mw, rw;
        int          lat;
        logic [31:0] rword;
        logic        exp_mis;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata, exp_load, exp_fwd;
    } vec_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_i = 1'b1;
    logic [31:0] alu_result_e_i = '0, write_data_e_i = '0, pc_target_e_i = '0;
    logic [31:0] pc_plus4_e_i = '0, imm_ext_e_i = '0;
    logic [4:0]  rd_e_i = '0;
    logic        valid_e_i = 1'b0, mem_write_e_i = 1'b0, reg_write_e_i = 1'b0;
    logic [2:0]  width_src_e_i = '0, result_src_e_i = '0;
    logic        stall_manual = 1'b0, flush_m_i = 1'b0;
    logic        dmem_ready_i = 1'b0;
    logic [31:0] dmem_rdata_i = '0;
    logic        stall_m_w;

    logic        dmem_req_o, dmem_we_o, mem_busy_o, misaligned_o;
    logic        reg_write_m_o, valid_m_o;
    logic [31:0] dmem_addr_o, dmem_wdata_o, alu_result_m_o, pc_plus4_m_o;
    logic [31:0] imm_ext_m_o, pc_target_m_o, load_data_m_o, forward_data_m_o;
    logic [3:0]  dmem_be_o;
    logic [4:0]  rd_m_o;
    logic [2:0]  result_src_m_o, width_src_m_o;
    logic [1:0]  m_state_o;

    // Hazard unit stand-in: hold M while the access is outstanding.
    assign stall_m_w = stall_manual | mem_busy_o;

    memory_stage dut (
        .clk_i(clk), .reset_i(reset_i),
        .alu_result_e_i(alu_result_e_i), .write_data_e_i(write_data_e_i),
        .pc_target_e_i(pc_target_e_i), .pc_plus4_e_i(pc_plus4_e_i),
        .imm_ext_e_i(imm_ext_e_i), .rd_e_i(rd_e_i), .valid_e_i(valid_e_i),
        .width_src_e_i(width_src_e_i), .result_src_e_i(result_src_e_i),
        .mem_write_e_i(mem_write_e_i), .reg_write_e_i(reg_write_e_i),
        .stall_m_i(stall_m_w), .flush_m_i(flush_m_i),
        .dmem_ready_i(dmem_ready_i), .dmem_rdata_i(dmem_rdata_i),
        .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
        .dmem_wdata_o(dmem_wdata_o), .dmem_be_o(dmem_be_o),
        .alu_result_m_o(alu_result_m_o), .pc_plus4_m_o(pc_plus4_m_o),
        .imm_ext_m_o(imm_ext_m_o), .pc_target_m_o(pc_target_m_o),
        .load_data_m_o(load_data_m_o), .forward_data_m_o(forward_data_m_o),
        .rd_m_o(rd_m_o), .reg_write_m_o(reg_write_m_o), .valid_m_o(valid_m_o),
        .result_src_m_o(result_src_m_o), .width_src_m_o(width_src_m_o),
        .mem_busy_o(mem_busy_o), .misaligned_o(misaligned_o), .m_state_o(m_state_o)
    );

    // ---------------- memory responder ----------------
    logic [31:0] mem_words [0:255];
    int resp_lat = 0;
    int wait_cnt = 0;

    always @(negedge clk) begin
        if (dmem_req_o) begin
            if (wait_cnt >= resp_lat) begin
                dmem_ready_i = 1'b1;
                dmem_rdata_i = mem_words[dmem_addr_o[9:2]];
                wait_cnt     = 0;
            end else begin
                dmem_ready_i = 1'b0;
                dmem_rdata_i = $urandom;
                wait_cnt     = wait_cnt + 1;
            end
        end else begin
            dmem_ready_i = 1'b0;
            dmem_rdata_i = $urandom;
            wait_cnt     = 0;
        end
    end

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int size_of(input logic [2:0] w);
        if (w == 3'b001 || w == 3'b101) return 1;
        if (w == 3'b010 || w == 3'b110) return 2;
        return 4;
    endfunction

    function automatic logic is_signed_w(input logic [2:0] w);
        return (w == 3'b001 || w == 3'b010);
    endfunction

    function automatic vec_t model(input vec_t v);
        vec_t   r = v;
        int     sz = size_of(v.width);
        int     off = int'(v.alu[1:0]);
        longint val;
        r.exp_mis   = v.valid && (v.mw || v.rsrc == 3'b001) && ((off % sz) != 0);
        r.exp_be    = v.mw ? 4'((((1 << sz) - 1) << off) & 15) : 4'hF;
        if (sz == 1)      r.exp_wdata = 32'(longint'(v.wd[7:0]) * 64'h01010101);
        else if (sz == 2) r.exp_wdata = 32'(longint'(v.wd[15:0]) * 64'h00010001);
        else              r.exp_wdata = v.wd;
        r.exp_load = 32'h0;
        if (v.valid && !v.mw && v.rsrc == 3'b001 && !r.exp_mis) begin
            val = (longint'(v.rword) >> (8 * off)) % (64'd1 << (8 * sz));
            if (is_signed_w(v.width) && sz < 4 && val >= (64'd1 << (8 * sz - 1)))
                val = val - (64'd1 << (8 * sz));
            r.exp_load = 32'(val);
        end
        case (v.rsrc)
            3'b010:  r.exp_fwd = v.pcp4;
            3'b011:  r.exp_fwd = v.imm;
            3'b100:  r.exp_fwd = v.pct;
            default: r.exp_fwd = v.alu;
        endcase
        return r;
    endfunction

    // ---------------- driver ----------------
    task automatic drive_e(input vec_t v);
        alu_result_e_i = v.alu;  write_data_e_i = v.wd;
        pc_plus4_e_i   = v.pcp4; pc_target_e_i  = v.pct;
        imm_ext_e_i    = v.imm;  rd_e_i         = v.rd;
        valid_e_i      = v.valid; width_src_e_i = v.width;
        result_src_e_i = v.rsrc; mem_write_e_i  = v.mw;
        reg_write_e_i  = v.rw;
    endtask

    task automatic apply(input vec_t v);
        int   cyc;
        logic s;
        logic exp_req;
        exp_req = v.valid && (v.mw || v.rsrc == 3'b001) && !v.exp_mis;
        mem_words[v.alu[9:2]] = v.rword;
        resp_lat = v.lat;
        @(negedge clk);
        stall_manual = 1'b0;
        drive_e(v);
        cyc = 0;
        do begin
            #1 s = stall_m_w;
            @(posedge clk);
            cyc++;
            if (s) @(negedge clk);
        end while (s && cyc < 50);
        if (s) chk("load_timeout", 32'(cyc), 32'd0);
        @(negedge clk);
        stall_manual = 1'b1;
        #1;
        chk("alu_m", alu_result_m_o, v.alu);
        chk("pcp4_m", pc_plus4_m_o, v.pcp4);
        chk("imm_m", imm_ext_m_o, v.imm);
        chk("pct_m", pc_target_m_o, v.pct);
        chk("rd_m", 32'(rd_m_o), 32'(v.rd));
        chk("ctl_m", {26'd0, valid_m_o, reg_write_m_o, result_src_m_o[1:0], width_src_m_o[1:0]},
            {26'd0, v.valid, v.rw, v.rsrc[1:0], v.width[1:0]});
        chk("fwd", forward_data_m_o, v.exp_fwd);
        chk("misaligned", 32'(misaligned_o), 32'(v.exp_mis));
        chk("req", 32'(dmem_req_o), 32'(exp_req));
        if (exp_req) begin
            chk("we", 32'(dmem_we_o), 32'(v.mw));
            chk("addr", dmem_addr_o, v.alu & 32'hFFFF_FFFC);
            chk("be", 32'(dmem_be_o), 32'(v.exp_be));
            if (v.mw) chk("wdata", dmem_wdata_o, v.exp_wdata);
        end
        cyc = 0;
        while (mem_busy_o && cyc < 50) begin
            cyc++;
            @(negedge clk);
            #1;
        end
        chk("busy_cycles", 32'(cyc), exp_req ? 32'(v.lat) : 32'd0);
        if (exp_req && !v.mw) chk("load_ready", load_data_m_o, v.exp_load);
        @(negedge clk);
        #1;
        chk("req_after", 32'(dmem_req_o), 32'd0);
        chk("state_after", 32'(m_state_o), exp_req ? 32'd2 : 32'd0);
        chk("load_hold", load_data_m_o, v.exp_load);
    endtask

    function automatic vec_t mk(input logic [31:0] alu, wd, pcp4, input logic [2:0] width,
                                input logic [2:0] rsrc, input logic mw, input int lat,
                                input logic [31:0] rword);
        vec_t v;
        v.alu = alu; v.wd = wd; v.pcp4 = pcp4; v.pct = 32'h0000_0400;
        v.imm = 32'h1234_5000; v.rd = 5'd7; v.valid = 1'b1;
        v.width = width; v.rsrc = rsrc; v.mw = mw; v.rw = ~mw; v.lat = lat;
        v.rword = rword;
        v.exp_mis = 1'b0; v.exp_be = 4'hF; v.exp_wdata = '0; v.exp_load = '0;
        v.exp_fwd = alu;
        return v;
    endfunction

    // ---------------- test ----------------
    vec_t tbl[$];
    vec_t v;
    logic [2:0] widths [0:4];

    initial begin
        for (int i = 0; i < 256; i++) mem_words[i] = $urandom;
        widths[0] = 3'b000; widths[1] = 3'b001; widths[2] = 3'b010;
        widths[3] = 3'b101; widths[4] = 3'b110;

        // Directed vectors with hand-computed expectations.
        v = mk(32'h1003, 32'h0000_00AB, 32'h0, 3'b001, 3'b000, 1'b1, 1, 32'h0);
        v.exp_be = 4'b1000; v.exp_wdata = 32'hABAB_ABAB; tbl.push_back(v);
        v = mk(32'h2002, 32'h0, 32'h0, 3'b001, 3'b001, 1'b0, 3, 32'h12F4_5678);
        v.exp_load = 32'hFFFF_FFF4; tbl.push_back(v);
        v = mk(32'h2002, 32'h0, 32'h0, 3'b101, 3'b001, 1'b0, 3, 32'h12F4_5678);
        v.exp_load = 32'h0000_00F4; tbl.push_back(v);
        v = mk(32'h2001, 32'h0, 32'h0, 3'b010, 3'b001, 1'b0, 0, 32'h1111_2222);
        v.exp_mis = 1'b1; tbl.push_back(v);
        v = mk(32'h0006, 32'h1234_BEEF, 32'h0, 3'b010, 3'b000, 1'b1, 2, 32'h0);
        v.exp_be = 4'b1100; v.exp_wdata = 32'hBEEF_BEEF; tbl.push_back(v);
        v = mk(32'h0042, 32'h0, 32'h0, 3'b110, 3'b001, 1'b0, 1, 32'h8001_7FFF);
        v.exp_load = 32'h0000_8001; tbl.push_back(v);
        v = mk(32'h0042, 32'h0, 32'h0, 3'b010, 3'b001, 1'b0, 0, 32'h8001_7FFF);
        v.exp_load = 32'hFFFF_8001; tbl.push_back(v);
        v = mk(32'h0010, 32'h0, 32'h0, 3'b000, 3'b001, 1'b0, 2, 32'hDEAD_BEEF);
        v.exp_load = 32'hDEAD_BEEF; tbl.push_back(v);
        v = mk(32'h0033, 32'h0, 32'h0, 3'b000, 3'b011, 1'b0, 0, 32'h0);
        v.exp_fwd = 32'h1234_5000; tbl.push_back(v);
        v = mk(32'h0034, 32'h0, 32'h0, 3'b000, 3'b100, 1'b0, 0, 32'h0);
        v.exp_fwd = 32'h0000_0400; tbl.push_back(v);
        v = mk(32'h0050, 32'h0, 32'h0104, 3'b000, 3'b010, 1'b0, 0, 32'h0);
        v.exp_fwd = 32'h0000_0104; tbl.push_back(v);

        // Reset values.
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_req", 32'(dmem_req_o), 32'd0);
        chk("rst_state", 32'(m_state_o), 32'd0);
        chk("rst_valid", 32'(valid_m_o), 32'd0);
        chk("rst_load", load_data_m_o, 32'd0);
        chk("rst_fwd", forward_data_m_o, 32'd0);
        reset_i = 1'b0;

        foreach (tbl[i]) apply(tbl[i]);

        // Flush after the PC+4 entry: flush wins over the held stall.
        @(negedge clk);
        flush_m_i = 1'b1;
        @(negedge clk);
        flush_m_i = 1'b0;
        #1;
        chk("flush_valid", 32'(valid_m_o), 32'd0);
        chk("flush_regw", 32'(reg_write_m_o), 32'd0);
        chk("flush_fwd", forward_data_m_o, 32'd0);

        // Back-to-back word loads, memory ready in the first access cycle.
        mem_words[8'h20] = 32'hCAFE_0001;
        mem_words[8'h21] = 32'h7777_0002;
        resp_lat = 0;
        @(negedge clk);
        stall_manual = 1'b0;
        v = mk(32'h0080, 32'h0, 32'h0, 3'b000, 3'b001, 1'b0, 0, 32'h0);
        drive_e(v);
        @(negedge clk);
        v.alu = 32'h0084;
        drive_e(v);
        #1;
        chk("b2b_busy1", 32'(mem_busy_o), 32'd0);
        chk("b2b_load1", load_data_m_o, 32'hCAFE_0001);
        @(negedge clk);
        v.valid = 1'b0;
        drive_e(v);
        #1;
        chk("b2b_busy2", 32'(mem_busy_o), 32'd0);
        chk("b2b_load2", load_data_m_o, 32'h7777_0002);
        @(negedge clk);
        #1;
        chk("b2b_idle", 32'(m_state_o), 32'd0);

        // Reset while an access is outstanding.
        resp_lat = 10;
        v = mk(32'h0030, 32'h0, 32'h0, 3'b000, 3'b001, 1'b0, 10, 32'h0);
        drive_e(v);
        @(negedge clk);
        stall_manual = 1'b1;
        @(negedge clk);
        #1;
        chk("rma_req", 32'(dmem_req_o), 32'd1);
        chk("rma_busy", 32'(mem_busy_o), 32'd1);
        reset_i = 1'b1;
        @(negedge clk);
        #1;
        chk("rma_req0", 32'(dmem_req_o), 32'd0);
        chk("rma_state", 32'(m_state_o), 32'd0);
        chk("rma_busy0", 32'(mem_busy_o), 32'd0);
        chk("rma_alu", alu_result_m_o, 32'd0);
        chk("rma_addr", dmem_addr_o, 32'd0);
        chk("rma_be", 32'(dmem_be_o), 32'd0);
        chk("rma_valid", 32'(valid_m_o), 32'd0);
        reset_i = 1'b0;

        // Randomized transactions against the model.
        for (int n = 0; n < 80; n++) begin
            int kind;
            kind = $urandom_range(0, 2);
            v.alu = $urandom; v.wd = $urandom; v.pcp4 = $urandom;
            v.pct = $urandom; v.imm = $urandom; v.rd = 5'($urandom);
            v.valid = ($urandom_range(0, 7) != 0);
            v.width = widths[$urandom_range(0, 4)];
            v.lat = $urandom_range(0, 3);
            v.rword = $urandom;
            v.rsrc = 3'($urandom_range(0, 7));
            if (v.rsrc == 3'b001) v.rsrc = 3'b000;
            v.mw = (kind == 2);
            if (kind == 1) v.rsrc = 3'b001;
            v.rw = ~v.mw;
            apply(model(v));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
